// File: rtl/otter_intc.sv
// OTTER interrupt controller: synchronises raw sources, latches them into PENDING,
// masks with ENABLE and exposes a CLAIM register holding the lowest-numbered active source.
module otter_intc #(
  parameter int unsigned NUM_SRC   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h1100_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [31:0]        iobus_addr,
  input  logic [31:0]        iobus_out,
  input  logic               iobus_wr,
  output logic [31:0]        rd_data,
  output logic               sel,
  output logic               intrpt
);

  localparam logic [2:0] RegPending = 3'd0;
  localparam logic [2:0] RegEnable  = 3'd1;
  localparam logic [2:0] RegMode    = 3'd2;
  localparam logic [2:0] RegClaim   = 3'd3;
  localparam logic [2:0] RegSwset   = 3'd4;

  logic [NUM_SRC-1:0] s1_q, s2_q, s3_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic               intrpt_q;

  logic [NUM_SRC-1:0] rise, src_set, sw_set, w1c_clr, claim_clr, active;
  logic [NUM_SRC-1:0] wdata;
  logic [31:0]        claim_id;
  logic               wr_en;
  logic [2:0]         reg_sel;
  logic               unused_addr;

  // Byte-lane bits carry no meaning; registers are word-addressed.
  assign unused_addr = ^iobus_addr[1:0];

  assign sel     = (iobus_addr[31:5] == BASE_ADDR[31:5]);
  assign wr_en   = iobus_wr & sel;
  assign reg_sel = iobus_addr[4:2];
  assign wdata   = iobus_out[NUM_SRC-1:0];

  assign rise    = s2_q & ~s3_q;
  assign src_set = (mode_q & rise) | (~mode_q & s2_q);
  assign active  = pending_q & enable_q;

  // Set terms are OR-ed last so a new event always beats a simultaneous clear.
  assign pending_d = src_set | sw_set | (pending_q & ~(w1c_clr | claim_clr));

  assign intrpt = intrpt_q;

  // Synchroniser chain plus history flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= irq_src;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Architectural registers and the registered interrupt request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      intrpt_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      intrpt_q  <= |active;
    end
  end

  // Register write decode for PENDING, ENABLE, MODE and SWSET.
  always_comb begin
    sw_set   = '0;
    w1c_clr  = '0;
    enable_d = enable_q;
    mode_d   = mode_q;
    if (wr_en) begin
      case (reg_sel)
        RegPending: w1c_clr  = wdata;
        RegEnable:  enable_d = wdata;
        RegMode:    mode_d   = wdata;
        RegSwset:   sw_set   = wdata;
        default:    ;
      endcase
    end
  end

  // CLAIM completion: value k in 1..NUM_SRC clears source k-1, anything else is ignored.
  always_comb begin
    claim_clr = '0;
    if (wr_en && (reg_sel == RegClaim)) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (iobus_out == 32'(i + 1)) begin
          claim_clr[i] = 1'b1;
        end
      end
    end
  end

  // Fixed priority: scan downwards so the lowest active index is the last to assign.
  always_comb begin
    claim_id = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (active[i]) begin
        claim_id = 32'(i + 1);
      end
    end
  end

  // Read mux; anything outside the window or unmapped reads zero.
  always_comb begin
    rd_data = '0;
    if (sel) begin
      case (reg_sel)
        RegPending: rd_data = 32'(pending_q);
        RegEnable:  rd_data = 32'(enable_q);
        RegMode:    rd_data = 32'(mode_q);
        RegClaim:   rd_data = claim_id;
        default:    rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_intc.sv
// Self-checking bench for otter_intc: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against a word-level model.
`timescale 1ns/1ps
module tb_otter_intc;

  localparam int unsigned N    = 8;
  localparam logic [31:0] BASE = 32'h1100_0000;
  localparam logic [31:0] MASK = (32'd1 << N) - 32'd1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  irq_src = '0;
  logic [31:0]   iobus_addr = BASE;
  logic [31:0]   iobus_out = '0;
  logic          iobus_wr = 1'b0;
  logic [31:0]   rd_data;
  logic          sel;
  logic          intrpt;

  otter_intc #(
    .NUM_SRC  (N),
    .BASE_ADDR(BASE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_src   (irq_src),
    .iobus_addr(iobus_addr),
    .iobus_out (iobus_out),
    .iobus_wr  (iobus_wr),
    .rd_data   (rd_data),
    .sel       (sel),
    .intrpt    (intrpt)
  );

  always #50 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state, whole words.
  bit [31:0] m_pend, m_en, m_mode;
  bit        m_intr;
  bit [31:0] hist [3];  // hist[k]: irq_src as sampled k+1 edges ago

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd32);
  endfunction

  function automatic logic [31:0] lowest_active();
    bit [31:0] act;
    act = m_pend & m_en;
    for (int i = 0; i < int'(N); i++) begin
      if (act[i]) return 32'(i + 1);
    end
    return 32'd0;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [31:0] reg_no;
    reg_no = (a - BASE) >> 2;
    case (reg_no)
      32'd0:   return m_pend;
      32'd1:   return m_en;
      32'd2:   return m_mode;
      32'd3:   return lowest_active();
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_mode = '0; m_intr = 1'b0;
    for (int k = 0; k < 3; k++) hist[k] = '0;
  endtask

  task automatic model_step();
    bit [31:0] lvl, rise, src, set_v, clr_v;
    logic [31:0] reg_no;
    lvl   = hist[1];
    rise  = hist[1] & ~hist[2];
    src   = ((m_mode & rise) | (~m_mode & lvl)) & MASK;
    set_v = '0;
    clr_v = '0;
    m_intr = ((m_pend & m_en) != 32'd0);
    if (iobus_wr && in_window(iobus_addr)) begin
      reg_no = (iobus_addr - BASE) >> 2;
      case (reg_no)
        32'd0: clr_v  = iobus_out & MASK;
        32'd1: m_en   = iobus_out & MASK;
        32'd2: m_mode = iobus_out & MASK;
        32'd3: if (iobus_out >= 32'd1 && iobus_out <= 32'(N)) clr_v = 32'd1 << (iobus_out - 32'd1);
        32'd4: set_v  = iobus_out & MASK;
        default: ;
      endcase
    end
    m_pend  = set_v | src | (m_pend & ~clr_v);
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = 32'(irq_src);
  endtask

  // Model follows the same clock and asynchronous reset as the DUT.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Continuous comparison mid-cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("sel", {31'd0, sel}, {31'd0, in_window(iobus_addr)});
      check("intrpt", {31'd0, intrpt}, {31'd0, m_intr});
      if (in_window(iobus_addr)) check("rd_data", rd_data, exp_read(iobus_addr));
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    iobus_addr = BASE + off;
    iobus_out  = d;
    iobus_wr   = 1'b1;
    tick();
    iobus_wr   = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] off, input logic [31:0] exp);
    iobus_addr = BASE + off;
    #1;
    check(name, rd_data, exp);
  endtask

  task automatic chk_irq(input string name, input bit exp);
    check(name, {31'd0, intrpt}, {31'd0, exp});
  endtask

  function automatic logic [N-1:0] rand_src();
    logic [31:0] r;
    r = $urandom;
    return r[N-1:0];
  endfunction

  initial begin
    repeat (3) tick();
    rd("reset pending", 32'h0, 32'h0);
    chk_irq("reset irq", 1'b0);
    rst_n = 1'b1;
    tick();

    // Reset mid-run with live pending state.
    wr(32'h10, 32'h05);
    wr(32'h04, 32'h05);
    wr(32'h08, 32'hFF);
    rd("pre-rst pending", 32'h0, 32'h05);
    chk_irq("pre-rst irq", 1'b1);
    rst_n = 1'b0;
    #1;
    rd("rst pending", 32'h0, 32'h0);
    rd("rst enable", 32'h4, 32'h0);
    rd("rst mode", 32'h8, 32'h0);
    chk_irq("rst irq", 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    rd("post-rst claim", 32'hC, 32'h0);

    // Edge-mode latency.
    wr(32'h08, 32'hFF);
    wr(32'h04, 32'h08);
    irq_src[3] = 1'b1;
    tick(); rd("edge E0 pending", 32'h0, 32'h0);
    tick(); rd("edge E1 pending", 32'h0, 32'h0);
    tick(); rd("edge E2 pending", 32'h0, 32'h08); chk_irq("edge E2 irq", 1'b0);
    tick(); chk_irq("edge E3 irq", 1'b1); rd("edge claim", 32'hC, 32'd4);
    wr(32'hC, 32'd4);
    rd("edge done pending", 32'h0, 32'h0);
    chk_irq("edge done lag", 1'b1);
    tick(); chk_irq("edge done irq", 1'b0);
    irq_src[3] = 1'b0;
    repeat (3) tick();

    // Fixed priority.
    wr(32'h04, 32'hFF);
    wr(32'h10, 32'h24);
    rd("prio claim 3", 32'hC, 32'd3);
    wr(32'hC, 32'd3);
    rd("prio claim 6", 32'hC, 32'd6);
    wr(32'hC, 32'd6);
    rd("prio claim 0", 32'hC, 32'd0);
    chk_irq("prio lag", 1'b1);
    tick(); chk_irq("prio irq low", 1'b0);

    // Level mode re-assertion.
    wr(32'h08, 32'h00);
    wr(32'h04, 32'h01);
    irq_src[0] = 1'b1;
    repeat (3) tick();
    rd("level pending", 32'h0, 32'h01);
    tick(); chk_irq("level irq", 1'b1);
    wr(32'h00, 32'h01);
    rd("level w1c held", 32'h0, 32'h01);
    tick();
    rd("level next", 32'h0, 32'h01);
    chk_irq("level irq held", 1'b1);
    irq_src[0] = 1'b0;
    repeat (3) tick();
    wr(32'h00, 32'h01);
    rd("level cleared", 32'h0, 32'h0);
    tick(); chk_irq("level irq low", 1'b0);

    // Masking and set/clear collision.
    wr(32'h04, 32'h00);
    wr(32'h10, 32'h02);
    rd("mask pending", 32'h0, 32'h02);
    tick(); chk_irq("mask irq", 1'b0);
    wr(32'h04, 32'h02);
    chk_irq("unmask lag", 1'b0);
    tick(); chk_irq("unmask irq", 1'b1);
    wr(32'h08, 32'h02);
    irq_src[1] = 1'b1;
    tick();
    tick();
    wr(32'h00, 32'h02);
    rd("collision set wins", 32'h0, 32'h02);
    wr(32'h00, 32'h02);
    rd("collision later clr", 32'h0, 32'h0);
    irq_src[1] = 1'b0;
    repeat (3) tick();

    // Address decode and unimplemented bits.
    wr(32'h04, 32'h5A);
    wr(32'h08, 32'h33);
    wr(32'h10, 32'h81);
    wr(32'h14, 32'hFFFF_FFFF);
    rd("dec pending", 32'h0, 32'h81);
    rd("dec enable", 32'h4, 32'h5A);
    rd("dec mode", 32'h8, 32'h33);
    rd("dec 0x14", 32'h14, 32'h0);
    rd("dec swset", 32'h10, 32'h0);
    wr(32'h20, 32'hFFFF_FFFF);
    wr(32'h24, 32'h0);
    iobus_addr = BASE + 32'h20;
    #1;
    check("dec sel out", {31'd0, sel}, 32'd0);
    rd("dec alias pending", 32'h0, 32'h81);
    rd("dec alias enable", 32'h4, 32'h5A);
    rd("dec 0x18", 32'h18, 32'h0);
    rd("dec 0x1C", 32'h1C, 32'h0);
    wr(32'h04, 32'hFFFF_FFFF);
    rd("enable upper bits", 32'h4, 32'hFF);
    wr(32'h07, 32'h11);
    rd("low addr bits", 32'h4, 32'h11);
    wr(32'hC, 32'd9);
    wr(32'hC, 32'd0);
    rd("claim bad values", 32'h0, 32'h81);
    rd("claim lowest", 32'hC, 32'd1);
    wr(32'h00, 32'hFF);
    wr(32'h04, 32'h00);
    wr(32'h08, 32'h00);

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 3) == 0) irq_src = irq_src ^ rand_src();
      iobus_wr = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) iobus_addr = $urandom;
      else iobus_addr = BASE + 32'($urandom_range(0, 32'h2F));
      if (iobus_addr[4:2] == 3'd3) iobus_out = 32'($urandom_range(0, N + 2));
      else iobus_out = $urandom;
      tick();
    end
    rst_n = 1'b1;
    iobus_wr = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
